// File: rtl/led_ctrl.sv
// Stop-the-light game controller: drives an external LED shifter and decides win/loss
// when the player stops or the LED bar overflows, then blinks the result.
module led_ctrl #(
    parameter int unsigned TICK_DIV    = 4,
    parameter int unsigned BLINK_TICKS = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [3:0]  target_i,
    input  logic [15:0] leds_i,
    output logic        load_o,
    output logic        shift_o,
    output logic        off_o,
    output logic [1:0]  state_o,
    output logic        win_o
);

    localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [TW-1:0] TickLast  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BlinkLast = BW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StRun    = 2'd2,
        StResult = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          off_q, off_d;
    logic          win_q, win_d;
    logic [15:0]   win_mask;
    logic          tick_term;
    logic          overflow;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            win_mask[i] = (i <= int'(target_i));
        end
    end

    assign tick_term = (tick_q == TickLast);
    assign overflow  = (leds_i == 16'hFFFF);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        blink_d = blink_q;
        off_d   = off_q;
        win_d   = win_q;
        load_o  = 1'b0;
        shift_o = 1'b0;
        case (state_q)
            StIdle: begin
                tick_d  = '0;
                blink_d = '0;
                off_d   = 1'b0;
                if (start_i) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                load_o  = 1'b1;
                tick_d  = '0;
                state_d = StRun;
            end
            StRun: begin
                tick_d = tick_term ? '0 : tick_q + TW'(1);
                // Stop wins over both overflow and a coincident tick; leds_i is pre-shift.
                if (stop_i || overflow) begin
                    win_d   = stop_i && (leds_i == win_mask);
                    state_d = StResult;
                    tick_d  = '0;
                    blink_d = '0;
                    off_d   = 1'b1;
                end else if (tick_term) begin
                    shift_o = 1'b1;
                end
            end
            StResult: begin
                if (tick_term) begin
                    tick_d = '0;
                    if (blink_q == BlinkLast) begin
                        state_d = StIdle;
                        blink_d = '0;
                        off_d   = 1'b0;
                    end else begin
                        blink_d = blink_q + BW'(1);
                        off_d   = ~off_q;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            tick_q  <= '0;
            blink_q <= '0;
            off_q   <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
            off_q   <= off_d;
            win_q   <= win_d;
        end
    end

    assign off_o   = off_q;
    assign state_o = state_q;
    assign win_o   = win_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with a behavioural LED shifter model feeding leds_i.
module tb_led_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [3:0]  target;
    logic [15:0] model;
    logic        load;
    logic        shift;
    logic        off;
    logic [1:0]  state;
    logic        win;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    led_ctrl #(
        .TICK_DIV   (4),
        .BLINK_TICKS(6)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .stop_i  (stop),
        .target_i(target),
        .leds_i  (model),
        .load_o  (load),
        .shift_o (shift),
        .off_o   (off),
        .state_o (state),
        .win_o   (win)
    );

    // Downstream shifter: load of switch value 0, shift-in of ones.
    always @(posedge clk or posedge rst) begin
        if (rst)        model <= 16'h0000;
        else if (load)  model <= 16'h0000;
        else if (shift) model <= {model[14:0], 1'b1};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input logic s_start, input logic s_stop);
        @(negedge clk);
        start = s_start;
        stop  = s_stop;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_load"},  32'(load),  0);
        check({tag, "_shift"}, 32'(shift), 0);
        check({tag, "_off"},   32'(off),   0);
        check({tag, "_win"},   32'(win),   0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && state != 2'd0; i++) step(1'b0, 1'b0);
        check(tag, 32'(state), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_sh;
        rst = 1'b1; start = 1'b0; stop = 1'b0; target = 4'd2;
        #12;
        check_all_zero("reset");
        rst = 1'b0;

        // Start sequence: load at cycle 1, shifts at 5, 9, 13
        step(1'b1, 1'b0);
        check("c0_state", 32'(state), 0);
        step(1'b0, 1'b0);
        check("c1_load",  32'(load),  1);
        check("c1_state", 32'(state), 1);
        for (int c = 2; c <= 13; c++) begin
            step(1'b0, 1'b0);
            check($sformatf("c%0d_state", c), 32'(state), 2);
            check($sformatf("c%0d_shift", c), 32'(shift), (c == 5 || c == 9 || c == 13) ? 1 : 0);
            check($sformatf("c%0d_load", c),  32'(load),  0);
        end

        // Win: stop at leds 0007 with target 2, then blink 1,0,1,0,1,0 per tick
        step(1'b0, 1'b1);
        check("win_leds",  32'(model), 32'h7);
        check("win_shift", 32'(shift), 0);
        step(1'b0, 1'b0);
        check("win_state", 32'(state), 3);
        check("win_win",   32'(win),   1);
        check("win_off0",  32'(off),   1);
        for (int k = 1; k <= 23; k++) begin
            step(1'b0, 1'b0);
            check($sformatf("blink%0d_off", k), 32'(off), ((k / 4) % 2 == 0) ? 1 : 0);
            check($sformatf("blink%0d_state", k), 32'(state), 3);
        end
        step(1'b0, 1'b0);
        check("blink_end_state", 32'(state), 0);
        check("blink_end_off",   32'(off),   0);
        check("win_hold",        32'(win),   1);

        // Wrong stop at leds 000F, start ignored in RESULT, async reset mid-RESULT
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int c = 2; c < 40 && model != 16'h000F; c++) step(1'b0, 1'b0);
        check("wrong_leds", 32'(model), 32'h000F);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("wrong_state", 32'(state), 3);
        check("wrong_win",   32'(win),   0);
        step(1'b1, 1'b0);
        check("res_start_state", 32'(state), 3);
        step(1'b0, 1'b0);
        check("res_start_state2", 32'(state), 3);
        check("res_start_load",   32'(load),  0);
        check("res_off_pre",      32'(off),   1);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_result");
        step(1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check($sformatf("post_rst%0d_state", i), 32'(state), 0);
        end

        // Overflow: no stop until leds reach FFFF
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 200 && model != 16'hFFFF; i++) step(1'b0, 1'b0);
        check("ovf_leds",  32'(model), 32'hFFFF);
        check("ovf_run",   32'(state), 2);
        check("ovf_shift", 32'(shift), 0);
        step(1'b0, 1'b0);
        check("ovf_state", 32'(state), 3);
        check("ovf_win",   32'(win),   0);
        n_sh = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0);
            if (shift) n_sh++;
        end
        check("ovf_no_shift", 32'(n_sh), 0);
        wait_idle("ovf_idle");

        // Collision: stop on terminal-count cycle 13 with leds 0003, target 1
        target = 4'd1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int c = 2; c <= 12; c++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("col_shift", 32'(shift), 0);
        check("col_leds",  32'(model), 32'h3);
        step(1'b0, 1'b0);
        check("col_state", 32'(state), 3);
        check("col_win",   32'(win),   1);
        check("col_leds_after", 32'(model), 32'h3);
        wait_idle("col_idle");

        // Start ignored mid-RUN, then async reset mid-RUN
        target = 4'd0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int c = 2; c <= 5; c++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("run_start_state", 32'(state), 2);
        step(1'b0, 1'b0);
        check("run_start_load",  32'(load),  0);
        check("run_start_state2", 32'(state), 2);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("run_c9_shift", 32'(shift), 1);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_run");
        step(1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        check("post_run_rst_state", 32'(state), 0);
        check("post_run_rst_leds",  32'(model), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 4, clock cycles per game tick (>=2).
REQ-002 Parameter BLINK_TICKS, default 6, ticks spent blinking in RESULT (>=1).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  one-cycle start request.
REQ-006 stop_i  input  1  one-cycle player stop request.
REQ-007 target_i  input  4  target index; win mask = bits [target_i:0] set, all others clear.
REQ-008 leds_i  input  16  current LED register value from the downstream LED shifter.
REQ-009 load_o  output  1  one-cycle pulse; the shifter loads its switch value.
REQ-010 shift_o  output  1  one-cycle pulse; the shifter shifts in one '1'.
REQ-011 off_o  output  1  level; the shifter blanks its LED outputs.
REQ-012 state_o  output  2  encoded state: IDLE=0, LOAD=1, RUN=2, RESULT=3.
REQ-013 win_o  output  1  result of the last game; 1 = win.

Function
REQ-014 The block SHALL implement a four-state FSM: IDLE, LOAD, RUN, RESULT.
REQ-015 IDLE: start_i=1 -> LOAD next cycle; stop_i is ignored.
REQ-016 LOAD SHALL last exactly one cycle, assert load_o=1 in that cycle, and go to RUN.
REQ-017 Entering RUN SHALL clear the tick counter to 0.
REQ-018 RUN: the counter increments each cycle and wraps TICK_DIV-1 -> 0.
REQ-019 shift_o SHALL be 1 only in RUN, when counter==TICK_DIV-1 and stop_i=0; first shift occurs TICK_DIV cycles after entering RUN.
REQ-020 RUN with stop_i=1: win_o <= (leds_i == win mask) using leds_i of that cycle; next state RESULT.
REQ-021 RUN with stop_i=0 and leds_i==16'hFFFF: win_o <= 0 (overflow loss); next state RESULT; no shift_o that cycle.
REQ-022 Simultaneous stop_i and tick terminal count: stop has priority, no shift_o issued.
REQ-023 start_i SHALL be ignored in LOAD, RUN and RESULT.
REQ-024 Entering RESULT SHALL clear the tick counter and a blink counter to 0.
REQ-025 RESULT: off_o toggles at each tick terminal count, starting from off_o=1 on the first RESULT cycle.
REQ-026 RESULT: after BLINK_TICKS ticks -> IDLE; off_o SHALL be 0 in IDLE.
REQ-027 win_o SHALL hold its value from the RUN exit until the next RUN exit.
REQ-028 load_o, shift_o and off_o SHALL be decoded only from registered state/counters, except for the stop_i gating of shift_o.
REQ-029 At most one of load_o and shift_o SHALL be 1 in any cycle.

Reset
REQ-030 rst_i=1 SHALL immediately force state IDLE, counters 0, win_o=0, load_o=0, shift_o=0, off_o=0, independent of clk_i.
REQ-031 Reset asserted mid-RUN or mid-RESULT SHALL abort the game; no pulse is issued after reset asserts.
REQ-032 After rst_i deasserts, the block SHALL wait in IDLE for start_i.

Verification
REQ-033 Start, TICK_DIV=4: start_i at cycle 0 -> load_o=1 at cycle 1; shift_o=1 at cycles 5, 9, 13; state_o=2 from cycle 2.
REQ-034 Win: target_i=2, model shifter from 0; stop_i while leds_i=16'h0007 -> win_o=1, state_o=3 next cycle, off_o blinks 1,0,1,0,1,0 per tick, IDLE after 24 cycles.
REQ-035 Wrong stop: target_i=2, stop_i while leds_i=16'h000F -> win_o=0, RESULT.
REQ-036 Overflow: no stop_i, leds_i reaches 16'hFFFF -> win_o=0, RESULT, no further shift_o.
REQ-037 Collision: stop_i on the terminal-count cycle -> shift_o=0 that cycle; evaluation uses the pre-shift leds_i.
REQ-038 Async reset mid-RUN and mid-RESULT -> all outputs 0, state_o=0 before the next clock edge; start_i during RUN/RESULT has no effect.
